// File: rtl/rx_move_pkg.sv
// Shared types and constants for the UART move-frame parser.
`timescale 1ns/1ps
package rx_move_pkg;
  localparam int BOARD_SIZE_DEF = 19;
  localparam int COORD_W_DEF    = 5;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {B0, B1, B2, B3, HOLD} moveStateT;
endpackage

// File: rtl/rx_move_parser_if.sv
// Receiver byte stream in, engine move handshake out, plus status pulses.
`timescale 1ns/1ps
interface rx_move_parser_if #(parameter int COORD_W = rx_move_pkg::COORD_W_DEF);
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_eop;
  logic [COORD_W-1:0] move_row;
  logic [COORD_W-1:0] move_col;
  logic               move_valid;
  logic               move_ready;
  logic               frame_err;
  logic               overrun;
  logic               busy;

  // master: receiver + engine side; slave: the parser
  modport master (output rx_data, rx_valid, rx_eop, move_ready,
                  input  move_row, move_col, move_valid, frame_err, overrun, busy);
  modport slave  (input  rx_data, rx_valid, rx_eop, move_ready,
                  output move_row, move_col, move_valid, frame_err, overrun, busy);
endinterface

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII decimal digit decoder.
`timescale 1ns/1ps
module ascii_digit_decode
  import rx_move_pkg::*;
(
  input  logic [7:0] byteIn,
  output logic       isDigit,
  output logic [3:0] value
);
  assign isDigit = (byteIn >= ASCII_0) && (byteIn <= ASCII_9);
  // low nibble of '0'..'9' is already the binary value
  assign value   = byteIn[3:0];
endmodule

// File: rtl/rx_move_parser.sv
// Assembles "RRCC" ASCII frames into board coordinates for the engine.
// Define RX_MOVE_EOP_ABORT_EN to make end-of-packet abort a partial frame.
`timescale 1ns/1ps
module rx_move_parser
  import rx_move_pkg::*;
#(
  parameter int BOARD_SIZE = BOARD_SIZE_DEF,
  parameter int COORD_W    = COORD_W_DEF
) (
  input logic clk,
  input logic rst,
  rx_move_parser_if.slave bus
);
  moveStateT  state;
  logic [3:0] rowTens, rowOnes, colTens;
  logic       isDigit;
  logic [3:0] digitVal;
  logic [6:0] rowFull, colFull;
  logic       inRange;
  logic       isCrLf;

  ascii_digit_decode uDec (.byteIn(bus.rx_data), .isDigit(isDigit), .value(digitVal));

  // column ones digit comes straight from the current byte
  assign rowFull = 7'(rowTens) * 7'd10 + 7'(rowOnes);
  assign colFull = 7'(colTens) * 7'd10 + 7'(digitVal);
  assign inRange = (rowFull != 7'd0) && (rowFull <= 7'(BOARD_SIZE)) &&
                   (colFull != 7'd0) && (colFull <= 7'(BOARD_SIZE));
  assign isCrLf  = (bus.rx_data == ASCII_CR) || (bus.rx_data == ASCII_LF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= B0;
      rowTens        <= '0;
      rowOnes        <= '0;
      colTens        <= '0;
      bus.move_row   <= '0;
      bus.move_col   <= '0;
      bus.move_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      case (state)
        B0: begin
          if (bus.rx_valid) begin
            if (isDigit) begin
              rowTens  <= digitVal;
              state    <= B1;
              bus.busy <= 1'b1;
            end else if (!isCrLf) begin
              bus.frame_err <= 1'b1;
            end
          end
        end
        B1, B2, B3: begin
          if (bus.rx_valid) begin
            if (!isDigit) begin
              bus.frame_err <= 1'b1;
              state         <= B0;
              bus.busy      <= 1'b0;
            end else if (state == B1) begin
              rowOnes <= digitVal;
              state   <= B2;
            end else if (state == B2) begin
              colTens <= digitVal;
              state   <= B3;
            end else begin
              bus.busy <= 1'b0;
              if (inRange) begin
                bus.move_row   <= COORD_W'(rowFull);
                bus.move_col   <= COORD_W'(colFull);
                bus.move_valid <= 1'b1;
                state          <= HOLD;
              end else begin
                bus.frame_err <= 1'b1;
                state         <= B0;
              end
            end
          end
`ifdef RX_MOVE_EOP_ABORT_EN
          else if (bus.rx_eop) begin
            bus.frame_err <= 1'b1;
            state         <= B0;
            bus.busy      <= 1'b0;
          end
`endif
        end
        HOLD: begin
          // nowhere to put a byte while a move is pending
          if (bus.rx_valid) bus.overrun <= 1'b1;
          if (bus.move_ready) begin
            bus.move_valid <= 1'b0;
            state          <= B0;
          end
        end
        default: begin
          state    <= B0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
